// File: rtl/mcycle_sequencer.sv
// Purpose: Z80 M-cycle sequencer; owns the external bus, times MRD/MWR/IORD/IOWR, delegates opcode fetch to OCF_fsm.
// Latency: accept edge to rsp_valid = 4 cycles for memory/IO (+ wait states, +1 IO auto-wait); OCF set by OCF_fsm.
// Backpressure: req_ready high only in IDLE with the bus not granted away; BUSREQ_L is honoured only between M-cycles.
//
// Ports:
//   clk, rst_L                  clock, async active-low reset
//   req_*                       decoder request (type 0=OCF 1=MRD 2=MWR 3=IORD 4=IOWR, 5-7 reserved)
//   rsp_valid, rsp_data         one-cycle completion pulse with read/opcode data (0 for writes, FF for reserved)
//   PC, OCF_start, OCF_*        opcode-fetch handshake and bus controls coming from OCF_fsm
//   data_in, WAIT_L, BUSREQ_L   external bus inputs
//   addr_out .. BUSACK_L        external bus outputs
// Build option: define IO_AUTO_WAIT_EN to insert one automatic wait state in every IO cycle.
module mcycle_sequencer #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_L,
   input  logic              req_valid,
   input  logic [2:0]        req_type,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] PC,
   output logic              OCF_start,
   input  logic              OCF_done,
   input  logic [DATA_W-1:0] OCF_opcode_out,
   input  logic              OCF_M1_L,
   input  logic              OCF_MREQ_L,
   input  logic              OCF_RD_L,
   input  logic              OCF_RFSH_L,
   input  logic [ADDR_W-1:0] OCF_addr_out,
   input  logic [DATA_W-1:0] data_in,
   input  logic              WAIT_L,
   input  logic              BUSREQ_L,
   output logic [ADDR_W-1:0] addr_out,
   output logic [DATA_W-1:0] data_out,
   output logic              data_oe,
   output logic              addr_oe,
   output logic              M1_L,
   output logic              MREQ_L,
   output logic              IORQ_L,
   output logic              RD_L,
   output logic              WR_L,
   output logic              RFSH_L,
   output logic              BUSACK_L
);

`ifdef IO_AUTO_WAIT_EN
   localparam bit IoAutoWait = 1'b1;
`else
   localparam bit IoAutoWait = 1'b0;
`endif

   localparam logic [2:0] TY_OCF  = 3'd0;
   localparam logic [2:0] TY_MRD  = 3'd1;
   localparam logic [2:0] TY_MWR  = 3'd2;
   localparam logic [2:0] TY_IORD = 3'd3;
   localparam logic [2:0] TY_IOWR = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE, S_OCF, S_T1, S_T2, S_TW, S_T3, S_BUSGNT
   } state_e;

   state_e            state_q, state_d;
   logic              busreq_q;
   logic [2:0]        type_q, type_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              ocf_first_q, ocf_first_d;

   logic accept;
   logic type_is_io;
   logic type_is_rd;
   logic in_t;    // T1..T3 including wait states
   logic late_t;  // T2..T3 including wait states

   assign req_ready  = (state_q == S_IDLE) && busreq_q && rst_L;
   assign accept     = req_valid && req_ready;
   assign type_is_io = (type_q == TY_IORD) || (type_q == TY_IOWR);
   assign type_is_rd = (type_q == TY_MRD) || (type_q == TY_IORD);
   assign in_t       = (state_q == S_T1) || late_t;
   assign late_t     = (state_q == S_T2) || (state_q == S_TW) || (state_q == S_T3);
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         state_q     <= S_IDLE;
         busreq_q    <= 1'b1;
         type_q      <= TY_OCF;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         ocf_first_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         busreq_q    <= BUSREQ_L;
         type_q      <= type_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         ocf_first_q <= ocf_first_d;
      end
   end

   // Next-state and completion logic.
   always_comb begin
      state_d     = state_q;
      type_d      = type_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      ocf_first_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            // A pending bus request wins over a new decoder request.
            if (!busreq_q) begin
               state_d = S_BUSGNT;
            end else if (accept) begin
               type_d  = req_type;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               case (req_type)
                  TY_OCF: begin
                     state_d     = S_OCF;
                     ocf_first_d = 1'b1;
                  end
                  TY_MRD, TY_MWR, TY_IORD, TY_IOWR: state_d = S_T1;
                  default: begin
                     // Reserved types complete at once with an all-ones response.
                     rsp_valid_d = 1'b1;
                     rsp_data_d  = {DATA_W{1'b1}};
                  end
               endcase
            end
         end
         S_OCF: begin
            if (OCF_done) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b1;
               rsp_data_d  = OCF_opcode_out;
            end
         end
         S_T1: state_d = S_T2;
         S_T2: state_d = (!WAIT_L || (IoAutoWait && type_is_io)) ? S_TW : S_T3;
         S_TW: state_d = !WAIT_L ? S_TW : S_T3;
         S_T3: begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b1;
            rsp_data_d  = type_is_rd ? data_in : '0;
         end
         S_BUSGNT: if (busreq_q) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Bus outputs decoded from the current state and latched cycle type.
   always_comb begin
      M1_L      = 1'b1;
      MREQ_L    = 1'b1;
      IORQ_L    = 1'b1;
      RD_L      = 1'b1;
      WR_L      = 1'b1;
      RFSH_L    = 1'b1;
      BUSACK_L  = 1'b1;
      addr_out  = '0;
      data_out  = '0;
      data_oe   = 1'b0;
      addr_oe   = 1'b1;
      PC        = '0;
      OCF_start = 1'b0;
      if (state_q == S_OCF) begin
         OCF_start = ocf_first_q;
         PC        = addr_q;
         M1_L      = OCF_M1_L;
         MREQ_L    = OCF_MREQ_L;
         RD_L      = OCF_RD_L;
         RFSH_L    = OCF_RFSH_L;
         addr_out  = OCF_addr_out;
      end else if (state_q == S_BUSGNT) begin
         BUSACK_L = 1'b0;
         addr_oe  = 1'b0;
      end else if (in_t) begin
         addr_out = addr_q;
         case (type_q)
            TY_MRD: begin
               MREQ_L = 1'b0;
               RD_L   = 1'b0;
            end
            TY_MWR: begin
               MREQ_L   = 1'b0;
               WR_L     = !late_t;
               data_oe  = 1'b1;
               data_out = wdata_q;
            end
            TY_IORD: begin
               IORQ_L = !late_t;
               RD_L   = !late_t;
            end
            TY_IOWR: begin
               IORQ_L   = !late_t;
               WR_L     = !late_t;
               data_oe  = 1'b1;
               data_out = wdata_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mcycle_sequencer.sv
module tb_mcycle_sequencer;

`ifdef IO_AUTO_WAIT_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif
   localparam int IO_RD_K   = AUTO ? 5 : 4;
   localparam int IO_IORQ_N = AUTO ? 3 : 2;

   logic        clk;
   logic        rst_L;
   logic        req_valid;
   logic [2:0]  req_type;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic        req_ready;
   logic        rsp_valid;
   logic [7:0]  rsp_data;
   logic [15:0] PC;
   logic        OCF_start;
   logic        OCF_done;
   logic [7:0]  OCF_opcode_out;
   logic        OCF_M1_L, OCF_MREQ_L, OCF_RD_L, OCF_RFSH_L;
   logic [15:0] OCF_addr_out;
   logic [7:0]  data_in;
   logic        WAIT_L;
   logic        BUSREQ_L;
   logic [15:0] addr_out;
   logic [7:0]  data_out;
   logic        data_oe, addr_oe;
   logic        M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L, BUSACK_L;

   mcycle_sequencer #(.ADDR_W(16), .DATA_W(8)) dut (
      .clk(clk), .rst_L(rst_L),
      .req_valid(req_valid), .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .PC(PC), .OCF_start(OCF_start), .OCF_done(OCF_done), .OCF_opcode_out(OCF_opcode_out),
      .OCF_M1_L(OCF_M1_L), .OCF_MREQ_L(OCF_MREQ_L), .OCF_RD_L(OCF_RD_L), .OCF_RFSH_L(OCF_RFSH_L),
      .OCF_addr_out(OCF_addr_out), .data_in(data_in), .WAIT_L(WAIT_L), .BUSREQ_L(BUSREQ_L),
      .addr_out(addr_out), .data_out(data_out), .data_oe(data_oe), .addr_oe(addr_oe),
      .M1_L(M1_L), .MREQ_L(MREQ_L), .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L),
      .RFSH_L(RFSH_L), .BUSACK_L(BUSACK_L)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   // Model of the transaction in flight: mode 0 none, 1 bus cycle, 2 opcode fetch, 3 reserved.
   int          mode = 0;
   int          acc_cyc;
   logic [2:0]  m_type;
   logic [15:0] m_addr;
   logic [7:0]  m_wdata, m_rdata, m_op;
   int          m_nw, m_breq, m_d;

   // Observations gathered by the compare process, checked against literals by the driver.
   int          rsp_k_seen;
   logic [7:0]  rsp_data_seen;
   int          mreq_lo, rd_lo, wr_lo, iorq_lo, oe_hi, start_cnt, m1_lo, rfsh_lo, iorq_first;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clear_obs();
      rsp_k_seen = -1; rsp_data_seen = 8'h00;
      mreq_lo = 0; rd_lo = 0; wr_lo = 0; iorq_lo = 0; oe_hi = 0;
      start_cnt = 0; m1_lo = 0; rfsh_lo = 0; iorq_first = -1;
   endtask

   task automatic ocf_idle();
      OCF_M1_L = 1'b1; OCF_MREQ_L = 1'b1; OCF_RD_L = 1'b1; OCF_RFSH_L = 1'b1;
      OCF_addr_out = 16'h0000; OCF_done = 1'b0; OCF_opcode_out = 8'h00;
   endtask

   // Memory/IO cycle. WAIT_L is low at the w edges starting with the one that ends T2;
   // BUSREQ_L drops from cycle breq_at (0 = never).
   task automatic run_bus(input logic [2:0] ty, input logic [15:0] a, input logic [7:0] wd,
                          input logic [7:0] rd, input int w, input int breq_at,
                          input int exp_k, input logic [7:0] exp_data);
      m_type = ty; m_addr = a; m_wdata = wd; m_rdata = rd; m_breq = breq_at;
      m_nw = (AUTO && (ty == 3'd3 || ty == 3'd4)) ? ((w > 1) ? w : 1) : w;
      clear_obs();
      req_valid = 1'b1; req_type = ty; req_addr = a; req_wdata = wd; data_in = rd;
      @(posedge clk); #1;
      acc_cyc = cyc; mode = 1;
      req_valid = 1'b0; req_addr = 16'h0000; req_wdata = 8'h00;
      for (int kk = 1; kk <= 4 + m_nw; kk++) begin
         WAIT_L = !(kk >= 2 && kk <= 1 + w);
         if (breq_at != 0 && kk >= breq_at) BUSREQ_L = 1'b0;
         @(posedge clk); #1;
      end
      mode = 0; WAIT_L = 1'b1;
      chk("rsp_latency", rsp_k_seen, exp_k);
      chk("rsp_data_literal", rsp_data_seen, exp_data);
   endtask

   // Opcode fetch with a stub OCF_fsm that finishes in its d-th cycle.
   task automatic run_ocf(input logic [15:0] a, input logic [7:0] op, input int d, input int exp_k);
      m_addr = a; m_op = op; m_d = d;
      clear_obs();
      req_valid = 1'b1; req_type = 3'd0; req_addr = a;
      @(posedge clk); #1;
      acc_cyc = cyc; mode = 2;
      req_valid = 1'b0; req_addr = 16'h0000;
      for (int kk = 1; kk <= d + 1; kk++) begin
         if (kk <= d) begin
            OCF_M1_L = !(kk <= 2); OCF_MREQ_L = !(kk <= 2); OCF_RD_L = !(kk <= 2);
            OCF_RFSH_L = !(kk >= 3);
            OCF_addr_out = (kk <= 2) ? a : 16'(16'h0040 + kk);
            OCF_done = (kk == d);
            OCF_opcode_out = (kk == d) ? op : 8'h00;
         end else begin
            ocf_idle();
         end
         @(posedge clk); #1;
      end
      mode = 0;
      chk("ocf_rsp_latency", rsp_k_seen, exp_k);
      chk("ocf_start_pulses", start_cnt, 1);
   endtask

   initial begin
      rst_L = 1'b0; req_valid = 1'b0; req_type = 3'd0; req_addr = 16'h0000; req_wdata = 8'h00;
      data_in = 8'h00; WAIT_L = 1'b1; BUSREQ_L = 1'b1;
      ocf_idle();
      fork
         // Compare process: every cycle a transaction is in flight, outputs against the model.
         forever begin
            int   k;
            logic in_t, late, is_m, is_w, is_io, is_rd, rsp_exp;
            @(negedge clk);
            k = cyc - acc_cyc + 1;
            if (mode == 1 && k >= 1 && k <= 4 + m_nw) begin
               in_t  = (k <= 3 + m_nw);
               late  = (k >= 2 && k <= 3 + m_nw);
               is_m  = (m_type == 3'd1 || m_type == 3'd2);
               is_w  = (m_type == 3'd2 || m_type == 3'd4);
               is_io = (m_type == 3'd3 || m_type == 3'd4);
               is_rd = (m_type == 3'd1 || m_type == 3'd3);
               rsp_exp = (k == 4 + m_nw);
               chk("MREQ_L", MREQ_L, !(is_m && in_t));
               chk("RD_L", RD_L, !((m_type == 3'd1 && in_t) || (m_type == 3'd3 && late)));
               chk("WR_L", WR_L, !(is_w && late));
               chk("IORQ_L", IORQ_L, !(is_io && late));
               chk("M1_RFSH_BUSACK", {M1_L, RFSH_L, BUSACK_L, addr_oe}, 4'hF);
               chk("addr_out", addr_out, in_t ? m_addr : 16'h0000);
               chk("data_oe", data_oe, is_w && in_t);
               chk("data_out", data_out, (is_w && in_t) ? m_wdata : 8'h00);
               chk("rsp_valid", rsp_valid, rsp_exp);
               if (rsp_exp) chk("rsp_data", rsp_data, is_rd ? m_rdata : 8'h00);
               chk("req_ready", req_ready, !in_t && !(m_breq != 0 && k > m_breq));
               chk("ocf_idle", {OCF_start, PC}, 17'h0);
            end else if (mode == 2 && k >= 1 && k <= m_d + 1) begin
               if (k <= m_d) begin
                  chk("ocf_M1_L", M1_L, OCF_M1_L);
                  chk("ocf_MREQ_L", MREQ_L, OCF_MREQ_L);
                  chk("ocf_RD_L", RD_L, OCF_RD_L);
                  chk("ocf_RFSH_L", RFSH_L, OCF_RFSH_L);
                  chk("ocf_addr_out", addr_out, OCF_addr_out);
                  chk("ocf_PC", PC, m_addr);
                  chk("ocf_start", OCF_start, k == 1);
                  chk("ocf_busy", {req_ready, rsp_valid, IORQ_L, WR_L, data_oe}, 5'b00110);
               end else begin
                  chk("ocf_rsp", {rsp_valid, req_ready, OCF_start}, 3'b110);
                  chk("ocf_rsp_data", rsp_data, m_op);
               end
            end else if (mode == 3 && k == 1) begin
               chk("rsv_rsp", {rsp_valid, req_ready, MREQ_L, IORQ_L}, 4'hF);
               chk("rsv_data", rsp_data, 8'hFF);
            end
            if (mode != 0) begin
               if (rsp_valid) begin rsp_k_seen = k; rsp_data_seen = rsp_data; end
               if (!MREQ_L) mreq_lo++;
               if (!RD_L) rd_lo++;
               if (!WR_L) wr_lo++;
               if (!IORQ_L) begin iorq_lo++; if (iorq_first < 0) iorq_first = k; end
               if (data_oe) oe_hi++;
               if (OCF_start) start_cnt++;
               if (!M1_L) m1_lo++;
               if (!RFSH_L) rfsh_lo++;
            end
         end
      join_none

      // Reset state.
      #12;
      chk("rst_controls", {M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L, BUSACK_L}, 7'h7F);
      chk("rst_addr_data", {addr_out, data_out}, 24'h0);
      chk("rst_oe", {data_oe, addr_oe}, 2'b01);
      chk("rst_handshake", {req_ready, rsp_valid, OCF_start}, 3'b000);
      chk("rst_rsp_pc", {rsp_data, PC}, 24'h0);
      @(posedge clk); #1; rst_L = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_reset", req_ready, 1'b1);

      run_bus(3'd1, 16'h1234, 8'h00, 8'h5A, 0, 0, 4, 8'h5A);
      chk("mrd_mreq_cycles", mreq_lo, 3);
      chk("mrd_rd_cycles", rd_lo, 3);

      run_bus(3'd2, 16'hBEEF, 8'hC3, 8'h99, 2, 0, 6, 8'h00);
      chk("mwr_wr_cycles", wr_lo, 4);
      chk("mwr_oe_cycles", oe_hi, 5);

      run_ocf(16'hBEEF, 8'h3E, 4, 5);
      chk("ocf_data_literal", rsp_data_seen, 8'h3E);
      chk("ocf_m1_cycles", m1_lo, 2);
      chk("ocf_rfsh_cycles", rfsh_lo, 2);

      run_bus(3'd3, 16'h00FE, 8'h00, 8'h77, 0, 0, IO_RD_K, 8'h77);
      chk("iord_iorq_cycles", iorq_lo, IO_IORQ_N);
      chk("iord_iorq_first", iorq_first, 2);

      run_bus(3'd4, 16'h00FF, 8'h81, 8'h00, 1, 0, 5, 8'h00);
      chk("iowr_oe_cycles", oe_hi, 4);

      run_bus(3'd1, 16'h8000, 8'h00, 8'h3C, 1, 0, 5, 8'h3C);

      // Reserved request type.
      clear_obs();
      req_valid = 1'b1; req_type = 3'd5; req_addr = 16'h0000;
      @(posedge clk); #1;
      acc_cyc = cyc; mode = 3; req_valid = 1'b0; req_type = 3'd0;
      @(posedge clk); #1;
      mode = 0;
      chk("rsv_latency", rsp_k_seen, 1);
      chk("rsv_data_literal", rsp_data_seen, 8'hFF);

      // Bus request raised during T2 of a memory read.
      run_bus(3'd1, 16'h2000, 8'h00, 8'hA5, 0, 2, 4, 8'hA5);
      @(negedge clk);
      chk("grant_state", {BUSACK_L, addr_oe, req_ready, data_oe, MREQ_L, RD_L}, 6'b000011);
      @(posedge clk); #1; BUSREQ_L = 1'b1;
      begin
         int n = 0;
         @(negedge clk);
         while (BUSACK_L == 1'b0 && n < 6) begin
            @(posedge clk); @(negedge clk);
            n++;
         end
         chk("busack_release_cycles", n, 2);
         chk("ready_after_grant", {BUSACK_L, req_ready, addr_oe}, 3'b111);
      end
      @(posedge clk); #1;

      // Reset during T2 of a memory write.
      clear_obs();
      m_type = 3'd2; m_addr = 16'h4321; m_wdata = 8'h5C; m_nw = 0; m_breq = 0;
      req_valid = 1'b1; req_type = 3'd2; req_addr = 16'h4321; req_wdata = 8'h5C;
      @(posedge clk); #1;
      acc_cyc = cyc; mode = 1; req_valid = 1'b0;
      @(posedge clk); #1;
      mode = 0;
      chk("wr_before_reset", {WR_L, MREQ_L, data_oe}, 3'b001);
      rst_L = 1'b0; #1;
      chk("abort_controls", {WR_L, MREQ_L, data_oe, req_ready, rsp_valid}, 5'b11000);
      chk("abort_addr", addr_out, 16'h0000);
      repeat (2) @(posedge clk);
      #1; rst_L = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("post_abort_rsp", rsp_valid, 1'b0);
         chk("post_abort_ready", req_ready, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mcycle_sequencer.md
Name: mcycle_sequencer

Overview:
- Z80 machine-cycle sequencer and bus owner; sits between the instruction decoder and the external pins.
- Accepts one M-cycle request at a time: opcode fetch, memory read/write, IO read/write.
- Opcode fetches are delegated to OCF_fsm through its start/done handshake. All other cycles are timed internally as T1/T2/Tw/T3.
- Arbitrates the external bus against BUSREQ_L (DMA) between M-cycles.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 8, data width.

Ports:
- clk  in  1  system clock
- rst_L  in  1  asynchronous active-low reset
- req_valid  in  1  decoder request
- req_type  in  3  0=OCF 1=MRD 2=MWR 3=IORD 4=IOWR, 5-7 reserved
- req_addr  in  ADDR_W  cycle address
- req_wdata  in  DATA_W  write data
- req_ready  out  1  sequencer can accept
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  DATA_W  read/opcode data
- PC  out  ADDR_W  fetch address to OCF_fsm
- OCF_start  out  1  start pulse to OCF_fsm
- OCF_done  in  1  OCF_fsm finished
- OCF_opcode_out  in  DATA_W  fetched opcode
- OCF_M1_L, OCF_MREQ_L, OCF_RD_L, OCF_RFSH_L  in  1 each  OCF_fsm bus controls
- OCF_addr_out  in  ADDR_W  OCF_fsm address
- data_in  in  DATA_W  external data bus
- WAIT_L  in  1  external wait
- BUSREQ_L  in  1  external bus request
- addr_out  out  ADDR_W  external address
- data_out  out  DATA_W  external write data
- data_oe  out  1  data bus drive enable
- addr_oe  out  1  address/control drive enable
- M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L  out  1 each  bus controls
- BUSACK_L  out  1  bus grant

Behaviour:
- Reset (async, rst_L=0):
  - state=IDLE.
  - All *_L outputs=1; addr_out=0, data_out=0; data_oe=0, addr_oe=1.
  - req_ready=0 (forced), rsp_valid=0, rsp_data=0, OCF_start=0, PC=0.
  - Reset mid-cycle aborts immediately; no rsp_valid is produced for the aborted request.
- BUSREQ_L is registered once (busreq_q) before use.
- req_ready = (state==IDLE) && busreq_q && rst_L. A request is accepted when req_valid && req_ready at a rising edge, latching type/addr/wdata.
- States: IDLE, OCF, T1, T2, TW, T3, BUSGNT.
  - IDLE -> BUSGNT if !busreq_q. Grant has priority over a simultaneous req_valid.
  - IDLE -> OCF on accept of type 0.
  - IDLE -> T1 on accept of types 1-4.
  - A reserved type is accepted, stays in IDLE, and gives rsp_valid next cycle with rsp_data=8'hFF.
  - OCF:
    - OCF_start=1 in the first OCF cycle only; PC=latched addr.
    - Bus outputs mux from the OCF_* inputs.
    - Wait for OCF_done; on OCF_done, capture OCF_opcode_out and go to IDLE.
  - T1 -> T2 -> (TW if WAIT_L==0 sampled at edge leaving T2 or TW, else T3) -> IDLE.
  - TW repeats while WAIT_L==0.
- Controls asserted per state (active low; unlisted outputs are 1):
  - MRD: MREQ_L, RD_L in T1..T3.
  - MWR: MREQ_L T1..T3; WR_L T2..T3; data_oe=1 and data_out=wdata T1..T3.
  - IORD: IORQ_L, RD_L in T2..T3.
  - IOWR: IORQ_L, WR_L T2..T3; data_oe T1..T3.
  - addr_out = latched addr T1..T3.
- Data capture and completion:
  - data_in is captured at the edge ending T3 for MRD/IORD.
  - rsp_valid pulses in the cycle after T3 or OCF completion, which is also an IDLE cycle with req_ready high. Back-to-back requests are legal.
  - rsp_data=0 for writes.
- Minimum latencies from accept edge to rsp_valid cycle: MRD/MWR 4 cycles; IO 4 cycles (5 with feature); OCF is set by OCF_fsm.
- BUSGNT:
  - BUSACK_L=0, addr_oe=0, data_oe=0, all controls 1.
  - Exit to IDLE when busreq_q==1; BUSACK_L=1 from that IDLE cycle.
- BUSREQ_L is never honoured mid-cycle. It waits for IDLE.

Optional Feature:
- Macro: IO_AUTO_WAIT_EN.
- When defined: IORD/IOWR always insert one TW after T2 regardless of WAIT_L. Further TW cycles follow while WAIT_L==0. Memory cycles are unaffected.
- When undefined: IO cycles time exactly like memory cycles.

Test Plan:
- Reset, then MRD addr=16'h1234 with data_in=8'h5A and WAIT_L=1 -> MREQ_L/RD_L low 3 cycles, addr_out=1234, rsp_valid 4 cycles after accept, rsp_data=5A.
- MWR addr=16'hBEEF wdata=8'hC3 with WAIT_L low for 2 edges -> two TW cycles, WR_L low T2..T3, data_oe high T1..T3, rsp_valid after 6 cycles.
- OCF addr=16'hBEEF, OCF_fsm model asserts OCF_done with opcode 8'h3E -> OCF_start one-cycle pulse, PC=BEEF, M1_L/RFSH_L mirror OCF inputs, rsp_data=3E.
- BUSREQ_L low during an MRD T2 -> cycle completes normally, then BUSGNT: BUSACK_L=0, addr_oe=0, req_ready=0. BUSREQ_L high -> BUSACK_L=1, req_ready=1.
- IORD addr=16'h00FE, with and without IO_AUTO_WAIT_EN -> rsp_valid at 5 vs 4 cycles after accept, IORQ_L low from T2.
- rst_L low during MWR T2 -> WR_L/MREQ_L=1 and data_oe=0 immediately, no rsp_valid, req_ready=1 after release.
